// File: rtl/riscv_pkg.sv
// Shared branch-unit definitions: funct3 branch encodings, resolve FSM state, flush counter width.
// Pure declarations, no logic.
package riscv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int FLUSH_CNT_W = 3;

    typedef logic [FLUSH_CNT_W-1:0] flush_cnt_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } br_state_t;

endpackage

// File: rtl/branch_cond.sv
// Flag-to-taken decode for conditional branches and jumps; flags come from A + ~B + 1.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller decides when the result is used.
module branch_cond
    import riscv_pkg::*;
(
    input  logic       is_jump,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       negative,
    input  logic       carry,
    input  logic       overflow,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        if (is_jump) begin
            taken = 1'b1;
        end else begin
            // carry set means no borrow, i.e. A >= B unsigned
            unique case (funct3)
                F3_BEQ:  taken = zero;
                F3_BNE:  taken = !zero;
                F3_BLT:  taken = negative ^ overflow;
                F3_BGE:  taken = !(negative ^ overflow);
                F3_BLTU: taken = !carry;
                F3_BGEU: taken = carry;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch/jump resolution: redirect pulse and FLUSH_CYCLES-long pipeline flush; BRANCH_STATS_EN adds counters.
// Latency: redirect/illegal one cycle after acceptance; flush_o starts the same cycle as redirect.
// Backpressure: br_ready_o low for the whole flush window; valids presented then are ignored.
module branch_resolve
    import riscv_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid_i,
    output logic        br_ready_o,
    input  logic        is_jump_i,
    input  logic [2:0]  funct3_i,
    input  logic        zero_i,
    input  logic        negative_i,
    input  logic        carry_i,
    input  logic        overflow_i,
    input  logic [31:0] target_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        illegal_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] br_count_o,
    output logic [31:0] taken_count_o
`endif
);

    localparam flush_cnt_t FLUSH_TERM = flush_cnt_t'(FLUSH_CYCLES);

    br_state_t  state, state_nxt;
    flush_cnt_t cnt, cnt_nxt, cnt_inc;
    logic       accept;
    logic       taken;
    logic       illegal;

    branch_cond u_cond (
        .is_jump  (is_jump_i),
        .funct3   (funct3_i),
        .zero     (zero_i),
        .negative (negative_i),
        .carry    (carry_i),
        .overflow (overflow_i),
        .taken    (taken),
        .illegal  (illegal)
    );

    assign accept  = br_valid_i && (state == ST_IDLE);
    assign cnt_inc = cnt + flush_cnt_t'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        br_ready_o = 1'b0;
        flush_o    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                br_ready_o = 1'b1;
                if (accept && taken) begin
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = '0;
                end
            end
            ST_FLUSH: begin
                flush_o = 1'b1;
                // exit at terminal count, so the 3-bit counter never wraps
                if (cnt_inc == FLUSH_TERM) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
            illegal_o     <= 1'b0;
        end else begin
            redirect_o    <= accept && taken;
            redirect_pc_o <= (accept && taken) ? target_i : '0;
            illegal_o     <= accept && illegal;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] br_count_q;
    logic [31:0] taken_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q    <= '0;
            taken_count_q <= '0;
        end else if (accept) begin
            br_count_q <= br_count_q + 32'd1;
            if (taken) begin
                taken_count_q <= taken_count_q + 32'd1;
            end
        end
    end

    assign br_count_o    = br_count_q;
    assign taken_count_o = taken_count_q;
`endif

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: number of cycles flush_o is held after a taken branch or jump; legal range 1..7.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port br_valid_i, input, 1: EX stage presents a branch or jump this cycle.
REQ-005 SHALL have port br_ready_o, output, 1: unit can accept a branch this cycle.
REQ-006 SHALL have port is_jump_i, input, 1: unconditional jump (JAL/JALR); flags are ignored when set.
REQ-007 SHALL have port funct3_i, input, 3: branch condition code (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
REQ-008 SHALL have ports zero_i, negative_i, carry_i, overflow_i, input, 1 each: flags from the ALU subtract (A + ~B + 1), where carry=1 means A>=B unsigned.
REQ-009 SHALL have port target_i, input, 32: resolved branch or jump target.
REQ-010 SHALL have port redirect_o, output, 1: one-cycle pulse that redirects fetch.
REQ-011 SHALL have port redirect_pc_o, output, 32: target, valid while redirect_o=1 and 0 otherwise.
REQ-012 SHALL have port flush_o, output, 1: clears the IF/ID and ID/EX pipeline registers.
REQ-013 SHALL have port illegal_o, output, 1: one-cycle pulse when funct3 is 010 or 011 on an accepted non-jump.

Function
REQ-014 SHALL accept a branch when br_valid_i and br_ready_o are both 1; inputs are sampled only at acceptance.
REQ-015 SHALL compute taken as follows: BEQ = zero; BNE = !zero; BLT = negative^overflow; BGE = !(negative^overflow); BLTU = !carry; BGEU = carry; jump = 1.
REQ-016 SHALL have a two-state FSM, IDLE and FLUSH; IDLE transitions to FLUSH on a taken acceptance, and FLUSH returns to IDLE once the flush counter reaches FLUSH_CYCLES.
REQ-017 SHALL, for an acceptance at edge N that is taken, drive redirect_o=1 and redirect_pc_o=target for the cycle after N only, with flush_o=1 for exactly FLUSH_CYCLES cycles starting in the same cycle.
REQ-018 SHALL drive br_ready_o = 1 in IDLE and 0 in FLUSH, a Moore output.
REQ-019 SHALL ignore br_valid_i asserted while in FLUSH; it causes no state change and no pulse.
REQ-020 SHALL, for a not-taken acceptance, leave the FSM in IDLE and keep redirect_o=flush_o=0, so back-to-back not-taken branches are accepted every cycle.
REQ-021 SHALL treat an illegal funct3 as not taken and pulse illegal_o=1 for the cycle after acceptance; illegal_o is 0 when is_jump_i=1.
REQ-022 SHALL use a 3-bit flush counter that is cleared on entry to FLUSH and never wraps, since exit occurs at terminal count.
REQ-023 SHALL, with FLUSH_CYCLES=1, return to IDLE and br_ready_o=1 in the cycle after the flush pulse.

Reset
REQ-024 SHALL, while rst=1 at an edge, set the FSM to IDLE, clear the counter, and drive redirect_o=0, redirect_pc_o=0, flush_o=0, illegal_o=0, br_ready_o=1.
REQ-025 SHALL abort a flush in progress when rst is asserted mid-FLUSH, with flush_o=0 from the next cycle; a branch presented in the reset cycle is dropped.

Configuration
REQ-026 SHALL, with BRANCH_STATS_EN defined, add outputs br_count_o[31:0] (accepted branches and jumps) and taken_count_o[31:0] (taken ones), both cleared by rst, incremented on acceptance, and wrapping from 0xFFFFFFFF to 0.
REQ-027 SHALL, without BRANCH_STATS_EN, omit both ports and the counters entirely, leaving all other behaviour identical.

Structure
REQ-028 SHALL place funct3 branch encodings, the FSM state type and the flush-counter width in the shared package riscv_pkg.
REQ-029 SHALL isolate the flag-to-taken decode in a combinational sub-module branch_cond.

Verification
REQ-030 SHALL cover BEQ with zero=1 and target 0x0000_0040: redirect_o pulses one cycle with redirect_pc_o=0x40, flush_o is high for 2 cycles, and br_ready_o is low for 2 cycles.
REQ-031 SHALL cover BLT with negative=1, overflow=1 (taken=0) on 3 consecutive cycles: all 3 are accepted, with no redirect and no flush.
REQ-032 SHALL cover BLTU with carry=0, then a valid BEQ during FLUSH: the second branch is ignored and exactly one redirect is seen.
REQ-033 SHALL cover funct3=011 with is_jump_i=0: illegal_o pulses once and there is no redirect; with is_jump_i=1, a redirect occurs and illegal_o=0.
REQ-034 SHALL cover rst asserted in the first flush cycle: flush_o=0 and br_ready_o=1 in the next cycle, with counters (if BRANCH_STATS_EN) equal to 0.
REQ-035 SHALL cover, with BRANCH_STATS_EN, 5 accepts of which 2 are taken: br_count_o=5 and taken_count_o=2; with br_count_o preloaded to 0xFFFFFFFF by force, one accept makes it 0.
